// File: rtl/alu_ctrl.sv
// Sequencing front-end for a 16-bit combinational ALU: command decode,
// 8-entry register file, operand staging, result capture and writeback.
module alu_ctrl #(
  parameter int NREGS = 8,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [15:0]  cmd_data,
  input  logic         ld_en,
  input  logic [2:0]   ld_addr,
  input  logic [W-1:0] ld_data,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_data,
  output logic [5:0]   rsp_flags,
  output logic         rsp_err,
  output logic [5:0]   status,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [3:0]   alu_sel,
  input  logic [W-1:0] alu_y,
  input  logic         alu_n,
  input  logic         alu_z,
  input  logic         alu_c,
  input  logic         alu_v,
  input  logic         alu_e,
  input  logic         alu_l
);

  typedef enum logic [1:0] {
    IDLE,
    OPRD,
    EXEC,
    RESP
  } state_t;

  state_t       state_q, state_d;
  logic [3:0]   op_q, op_d;
  logic [2:0]   rd_q, rd_d;
  logic [2:0]   rs1_q, rs1_d;
  logic [2:0]   rs2_q, rs2_d;
  logic         nowb_q, nowb_d;
  logic [W-1:0] rf_q [NREGS];
  logic [W-1:0] rf_d [NREGS];
  logic [5:0]   status_q, status_d;
  logic [W-1:0] alu_a_q, alu_a_d;
  logic [W-1:0] alu_b_q, alu_b_d;
  logic [3:0]   alu_sel_q, alu_sel_d;
  logic [W-1:0] rsp_data_q, rsp_data_d;
  logic [5:0]   rsp_flags_q, rsp_flags_d;
  logic         rsp_err_q, rsp_err_d;

  logic [5:0]   alu_flags;
  logic         div_zero;
  logic         unused_rsvd;

  // Reserved instruction bits are accepted and ignored.
  assign unused_rsvd = ^cmd_data[2:1];

  assign alu_flags = {alu_n, alu_z, alu_c,
                      alu_v, alu_e, alu_l};
  assign div_zero  = ((alu_sel_q == 4'd3) ||
                      (alu_sel_q == 4'd4)) &&
                     (alu_b_q == '0);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rd_d        = rd_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    nowb_d      = nowb_q;
    rf_d        = rf_q;
    status_d    = status_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    rsp_data_d  = rsp_data_q;
    rsp_flags_d = rsp_flags_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      IDLE: begin
        if (ld_en) rf_d[ld_addr] = ld_data;
        if (cmd_valid) begin
          op_d    = cmd_data[15:12];
          rd_d    = cmd_data[11:9];
          rs1_d   = cmd_data[8:6];
          rs2_d   = cmd_data[5:3];
          nowb_d  = cmd_data[0];
          state_d = OPRD;
        end
      end
      OPRD: begin
        alu_a_d   = rf_q[rs1_q];
        alu_b_d   = rf_q[rs2_q];
        alu_sel_d = op_q;
        state_d   = EXEC;
      end
      EXEC: begin
        if (div_zero) begin
          rsp_data_d  = '1;
          rsp_flags_d = '0;
          rsp_err_d   = 1'b1;
        end else begin
          rsp_data_d  = alu_y;
          rsp_flags_d = alu_flags;
          rsp_err_d   = 1'b0;
          status_d    = alu_flags;
          if (!nowb_q) rf_d[rd_q] = alu_y;
        end
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= '0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      nowb_q      <= 1'b0;
      for (int i = 0; i < NREGS; i++)
        rf_q[i] <= '0;
      status_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      nowb_q      <= nowb_d;
      rf_q        <= rf_d;
      status_q    <= status_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flags_q <= rsp_flags_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_flags = rsp_flags_q;
  assign rsp_err   = rsp_err_q;
  assign status    = status_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;

endmodule
